// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width sizing and wrap-around pointer increment,
// plus the per-cycle accepted-operation bundle used by the FIFO top.
package fifo_pkg;

   typedef struct packed {
      logic wr;
      logic rd;
   } fifo_op_t;

   // Pointer width for a buffer of `depth` entries, never narrower than one bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : unsigned'($clog2(depth));
   endfunction

   // Advance a circular pointer, wrapping from depth-1 back to zero (any depth, not only powers of two).
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_circ_mem.sv
// FIFO storage array: synchronous write port, registered read port.
// Only the read register is reset; array contents survive reset.
module fifo_circ_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int PTR_W = ptr_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [PTR_W-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [PTR_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read stage: the word leaves the array one cycle after its read is accepted and is held otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_circ.sv
// Circular-buffer FIFO with registered read data, occupancy count and almost-full/empty flags.
// Define FIFO_CIRC_ERR_EN to add sticky overflow/underflow outputs.
module fifo_circ
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int AFULL_LVL  = FIFO_DEPTH - 2,
   parameter int AEMPTY_LVL = 2,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic                  wr_ready,
   output logic                  rd_val,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0]      count,
   output logic                  almost_full,
   output logic                  almost_empty
`ifdef FIFO_CIRC_ERR_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int PTR_W = ptr_width(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   fifo_op_t         op;

   // Status comes from registered count only, so wr_en/rd_en never reach wr_ready/rd_val.
   assign wr_ready     = (count < DEPTH_C);
   assign rd_val       = (count != '0);
   assign almost_full  = (int'(count) >= AFULL_LVL);
   assign almost_empty = (int'(count) <= AEMPTY_LVL);

   assign op.wr = wr_en && wr_ready;
   assign op.rd = rd_en && rd_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (op.wr) begin
            wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
         end
         if (op.rd) begin
            rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
         end
         case ({op.wr, op.rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   fifo_circ_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (op.wr),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (op.rd),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

`ifdef FIFO_CIRC_ERR_EN
   // Sticky misuse flags: set on any refused request, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_ready) begin
            overflow <= 1'b1;
         end
         if (rd_en && !rd_val) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_circ.sv
// Directed bench for fifo_circ: a depth-4 instance for fill/drain/boundary/reset
// and a depth-5 instance for pointer wrap.
module tb_fifo_circ;

   logic clk;
   logic reset;

   logic       w4_en, r4_en;
   logic [7:0] w4_data;
   logic       wr_ready4, rd_val4, afull4, aempty4;
   logic [7:0] rd_data4;
   logic [2:0] count4;

   logic       w5_en, r5_en;
   logic [7:0] w5_data;
   logic       wr_ready5, rd_val5, afull5, aempty5;
   logic [7:0] rd_data5;
   logic [2:0] count5;

`ifdef FIFO_CIRC_ERR_EN
   logic ovf4, unf4, ovf5, unf5;
`endif

   int checks = 0;
   int errors = 0;

   fifo_circ #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u4 (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (w4_en),
      .wr_data      (w4_data),
      .rd_en        (r4_en),
      .wr_ready     (wr_ready4),
      .rd_val       (rd_val4),
      .rd_data      (rd_data4),
      .count        (count4),
      .almost_full  (afull4),
      .almost_empty (aempty4)
`ifdef FIFO_CIRC_ERR_EN
      ,
      .overflow     (ovf4),
      .underflow    (unf4)
`endif
   );

   fifo_circ #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u5 (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (w5_en),
      .wr_data      (w5_data),
      .rd_en        (r5_en),
      .wr_ready     (wr_ready5),
      .rd_val       (rd_val5),
      .rd_data      (rd_data5),
      .count        (count5),
      .almost_full  (afull5),
      .almost_empty (aempty5)
`ifdef FIFO_CIRC_ERR_EN
      ,
      .overflow     (ovf5),
      .underflow    (unf5)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      w4_en = 1'b0; r4_en = 1'b0; w4_data = 8'h00;
      w5_en = 1'b0; r5_en = 1'b0; w5_data = 8'h00;

      // Reset state
      #2;
      chk("rst_count",  32'(count4),    0);
      chk("rst_wr_rdy", 32'(wr_ready4), 1);
      chk("rst_rd_val", 32'(rd_val4),   0);
      chk("rst_aempty", 32'(aempty4),   1);
      chk("rst_afull",  32'(afull4),    0);
      chk("rst_rdata",  32'(rd_data4),  0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Fill depth-4 with A1..A4
      for (int k = 0; k < 4; k++) begin
         w4_en = 1'b1; w4_data = 8'(8'hA1 + k);
         tick();
      end
      w4_en = 1'b0;
      chk("fill_count",  32'(count4),    4);
      chk("fill_wr_rdy", 32'(wr_ready4), 0);
      chk("fill_afull",  32'(afull4),    1);
      chk("fill_rd_val", 32'(rd_val4),   1);

      // Full: write+read together -> only the read is accepted
      w4_en = 1'b1; w4_data = 8'hEE; r4_en = 1'b1;
      tick();
      w4_en = 1'b0;
      chk("full_wr_rd_count", 32'(count4),   3);
      chk("drain_rd0",        32'(rd_data4), 'hA1);
      tick();
      chk("drain_rd1", 32'(rd_data4), 'hA2);
      tick();
      chk("drain_rd2", 32'(rd_data4), 'hA3);
      tick();
      chk("drain_rd3", 32'(rd_data4), 'hA4);
      r4_en = 1'b0;
      chk("drain_count",  32'(count4),  0);
      chk("drain_rd_val", 32'(rd_val4), 0);
      chk("drain_aempty", 32'(aempty4), 1);
      tick();
      chk("hold_rdata", 32'(rd_data4), 'hA4);

      // Empty: write+read together -> only the write, rd_data unchanged
      w4_en = 1'b1; w4_data = 8'h55; r4_en = 1'b1;
      tick();
      w4_en = 1'b0;
      chk("empty_wr_rd_count", 32'(count4),   1);
      chk("empty_wr_rd_rdata", 32'(rd_data4), 'hA4);
      chk("empty_wr_rd_val",   32'(rd_val4),  1);
      tick();
      r4_en = 1'b0;
      chk("after_empty_rd", 32'(rd_data4), 'h55);
      chk("after_empty_cnt", 32'(count4),  0);
      r4_en = 1'b1;
      tick();
      r4_en = 1'b0;
      chk("rd_while_empty_rdata", 32'(rd_data4), 'h55);
      chk("rd_while_empty_count", 32'(count4),   0);

      // Simultaneous access at count=2
      w4_en = 1'b1; w4_data = 8'h11;
      tick();
      w4_data = 8'h22;
      tick();
      chk("sim_pre_count", 32'(count4), 2);
      chk("sim_pre_afull", 32'(afull4), 1);
      r4_en = 1'b1;
      w4_data = 8'h33;
      tick();
      chk("sim_rd0", 32'(rd_data4), 'h11);
      chk("sim_cnt0", 32'(count4), 2);
      w4_data = 8'h44;
      tick();
      chk("sim_rd1", 32'(rd_data4), 'h22);
      chk("sim_cnt1", 32'(count4), 2);
      w4_data = 8'h66;
      tick();
      chk("sim_rd2", 32'(rd_data4), 'h33);
      chk("sim_cnt2", 32'(count4), 2);
      w4_en = 1'b0;
      tick();
      chk("sim_rd3", 32'(rd_data4), 'h44);
      tick();
      r4_en = 1'b0;
      chk("sim_rd4", 32'(rd_data4), 'h66);
      chk("sim_end_count", 32'(count4), 0);

      // Wrap on depth-5: 12 write/read pairs
      for (int k = 0; k < 12; k++) begin
         w5_en = 1'b1; w5_data = 8'(k + 8'h30);
         tick();
         w5_en = 1'b0;
         chk($sformatf("wrap_cnt_w%0d", k), 32'(count5), 1);
         r5_en = 1'b1;
         tick();
         r5_en = 1'b0;
         chk($sformatf("wrap_rd%0d", k), 32'(rd_data5), 32'(k + 'h30));
         chk($sformatf("wrap_cnt_r%0d", k), 32'(count5), 0);
      end

      // Mid-operation asynchronous reset at count=3
      w4_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         w4_data = 8'(8'h61 + k);
         tick();
      end
      w4_en = 1'b0;
      chk("pre_rst_count", 32'(count4), 3);
      chk("pre_rst_aempty", 32'(aempty4), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_count",  32'(count4),    0);
      chk("mid_rst_rd_val", 32'(rd_val4),   0);
      chk("mid_rst_rdata",  32'(rd_data4),  0);
      chk("mid_rst_wr_rdy", 32'(wr_ready4), 1);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_rst_count", 32'(count4), 0);
      w4_en = 1'b1; w4_data = 8'h77;
      tick();
      w4_en = 1'b0; r4_en = 1'b1;
      tick();
      r4_en = 1'b0;
      chk("post_rst_rd", 32'(rd_data4), 'h77);
      chk("post_rst_cnt", 32'(count4), 0);

`ifdef FIFO_CIRC_ERR_EN
      // Sticky error flags
      chk("err_init_ovf", 32'(ovf4), 0);
      w4_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         w4_data = 8'(k);
         tick();
      end
      w4_en = 1'b0;
      chk("err_ovf_set", 32'(ovf4), 1);
      chk("err_unf_clr", 32'(unf4), 0);
      r4_en = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      r4_en = 1'b0;
      chk("err_ovf_sticky", 32'(ovf4), 1);
      chk("err_unf_still0", 32'(unf4), 0);
      r4_en = 1'b1;
      tick();
      r4_en = 1'b0;
      chk("err_unf_set", 32'(unf4), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("err_rst_ovf", 32'(ovf4), 0);
      chk("err_rst_unf", 32'(unf4), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
